// File: rtl/wb_burst_master.sv
// Wishbone B3 incrementing-burst traffic master: writes an LFSR pattern or reads and checks it.
// Optional ack watchdog enabled by defining WBM_TIMEOUT_EN.
module wb_burst_master #(
  parameter int DW     = 32,
  parameter int AW     = 26,
  parameter int BL     = 5,
  parameter int TO_CYC = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            sdr_init_done,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [BL-1:0]   cmd_len,
  input  logic [31:0]     cmd_seed,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [2:0]      wb_cti_o,
  output logic [1:0]      wb_bte_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  output logic            busy,
  output logic            done,
  input  logic            err_clr,
  output logic [15:0]     err_cnt,
  output logic [AW-1:0]   err_addr,
  output logic            err_vld,
  output logic            timeout
);

  localparam int          SW       = DW / 8;
  localparam logic [31:0] POLY     = 32'h0040_0007;  // x^22 + x^2 + x + 1 taps
  localparam logic [2:0]  CTI_INCR = 3'b010;
  localparam logic [2:0]  CTI_LAST = 3'b111;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    state;
  logic [BL-1:0] beats;
  logic [31:0]   lfsr;
  logic [31:0]   lfsr_nxt;
  logic [31:0]   seed_eff;
  logic [AW-1:0] addr_aligned;
  logic          last_beat;
  logic          to_hit;
  logic          end_burst;
  logic          mismatch;

  function automatic logic [DW-1:0] pattern(input logic [31:0] v);
    logic [DW-1:0] p;
    for (int i = 0; i < DW; i++) p[i] = v[i % 32];
    return p;
  endfunction

  assign lfsr_nxt     = {lfsr[30:0], 1'b0} ^ (lfsr[31] ? POLY : 32'h0);
  assign seed_eff     = (cmd_seed == 32'h0) ? 32'h1 : cmd_seed;
  assign addr_aligned = cmd_addr & ~AW'(SW - 1);
  assign last_beat    = (beats == '0);
  assign cmd_ready    = (state == S_IDLE) && sdr_init_done;
  assign wb_bte_o     = 2'b00;
  assign end_burst    = (state == S_BURST) && (to_hit || (wb_ack_i && last_beat));
  assign mismatch     = (state == S_BURST) && wb_ack_i && !wb_we_o &&
                        (wb_dat_i != pattern(lfsr));

`ifdef WBM_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);
  logic [TW-1:0] to_cnt;

  assign to_hit = (state == S_BURST) && !wb_ack_i && (to_cnt == TW'(TO_CYC - 1));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || state != S_BURST || wb_ack_i) to_cnt <= '0;
    else                                          to_cnt <= to_cnt + 1'b1;
  end

  // A watchdog hit in the same cycle as err_clr still reports the new timeout.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)     timeout <= 1'b0;
    else if (to_hit)  timeout <= 1'b1;
    else if (err_clr) timeout <= 1'b0;
  end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= S_IDLE;
      beats    <= '0;
      lfsr     <= 32'h0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_sel_o <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_cti_o <= 3'b000;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            state    <= S_BURST;
            beats    <= cmd_len;
            lfsr     <= seed_eff;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= cmd_we;
            wb_sel_o <= '1;
            wb_adr_o <= addr_aligned;
            wb_dat_o <= cmd_we ? pattern(seed_eff) : '0;
            wb_cti_o <= (cmd_len == '0) ? CTI_LAST : CTI_INCR;
            busy     <= 1'b1;
          end
        end
        S_BURST: begin
          if (end_burst) begin
            state    <= S_DONE;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= '0;
            wb_cti_o <= 3'b000;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else if (wb_ack_i) begin
            // Without an ack every bus output simply holds its registered value.
            beats    <= beats - 1'b1;
            lfsr     <= lfsr_nxt;
            wb_adr_o <= wb_adr_o + AW'(SW);
            wb_dat_o <= wb_we_o ? pattern(lfsr_nxt) : '0;
            wb_cti_o <= (beats == BL'(1)) ? CTI_LAST : CTI_INCR;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // err_clr coinciding with a mismatch restarts the record from that beat.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      err_cnt  <= 16'h0;
      err_addr <= '0;
      err_vld  <= 1'b0;
    end else if (err_clr) begin
      err_cnt  <= mismatch ? 16'h1 : 16'h0;
      err_addr <= mismatch ? wb_adr_o : '0;
      err_vld  <= mismatch;
    end else if (mismatch) begin
      if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
      if (!err_vld) begin
        err_addr <= wb_adr_o;
        err_vld  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed self-checking bench for wb_burst_master with an echoing Wishbone slave model.
module tb_wb_burst_master;
  localparam int DW = 32, AW = 26, BL = 5, TO_CYC = 8;

  logic          wb_clk_i, wb_rst_i, sdr_init_done;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [BL-1:0] cmd_len;
  logic [31:0]   cmd_seed;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]    wb_sel_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic [2:0]    wb_cti_o;
  logic [1:0]    wb_bte_o;
  logic          wb_ack_i, busy, done, err_clr, err_vld, timeout;
  logic [15:0]   err_cnt;
  logic [AW-1:0] err_addr;

  int checks = 0, failures = 0, done_cnt = 0;
  logic          ack_en = 1'b1, corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_adr = '0;
  bit   [31:0]   mem [0:1023];

  logic [AW-1:0] log_adr[$];
  logic [2:0]    log_cti[$];
  logic [DW-1:0] log_dat[$];
  logic [3:0]    log_sel[$];
  logic          log_we[$];

  wb_burst_master #(.DW(DW), .AW(AW), .BL(BL), .TO_CYC(TO_CYC)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .sdr_init_done(sdr_init_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .busy(busy), .done(done), .err_clr(err_clr),
    .err_cnt(err_cnt), .err_addr(err_addr), .err_vld(err_vld), .timeout(timeout)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // Zero-wait slave: acks every strobed cycle, echoes stored data, optionally corrupts one address.
  assign wb_ack_i = wb_cyc_o & wb_stb_o & ack_en;
  assign wb_dat_i = mem[wb_adr_o[11:2]] ^
                    ((corrupt_en && wb_adr_o == corrupt_adr) ? 32'h0000_00FF : 32'h0);

  always @(posedge wb_clk_i)
    if (wb_ack_i && wb_we_o) mem[wb_adr_o[11:2]] <= wb_dat_o;

  always @(negedge wb_clk_i) begin
    if (done === 1'b1) done_cnt++;
    if (wb_ack_i === 1'b1) begin
      log_adr.push_back(wb_adr_o);
      log_cti.push_back(wb_cti_o);
      log_dat.push_back(wb_dat_o);
      log_sel.push_back(wb_sel_o);
      log_we.push_back(wb_we_o);
    end
  end

  task automatic clear_log();
    log_adr.delete(); log_cti.delete(); log_dat.delete(); log_sel.delete(); log_we.delete();
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [BL-1:0] len,
                       input logic [31:0] seed);
    int n = 0;
    @(negedge wb_clk_i);
    cmd_we = we; cmd_addr = addr; cmd_len = len; cmd_seed = seed; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin @(negedge wb_clk_i); n++; end
    if (!cmd_ready) begin
      checks++; failures++;
      $display("FAIL issue_accept: cmd_ready=%0b required 1", cmd_ready);
    end
    @(posedge wb_clk_i); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    @(negedge wb_clk_i);
    while (done !== 1'b1 && n < 200) begin @(negedge wb_clk_i); n++; end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_done: done=%0b busy=%0b required done=1 busy=0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1; sdr_init_done = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0;
    cmd_addr = '0; cmd_len = '0; cmd_seed = '0; err_clr = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o, wb_cti_o, wb_bte_o,
         busy, done, err_cnt, err_addr, err_vld, timeout, cmd_ready} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: cyc=%0b adr=%0h dat=%0h cti=%0b sel=%0h busy=%0b err_cnt=%0h required all 0",
               wb_cyc_o, wb_adr_o, wb_dat_o, wb_cti_o, wb_sel_o, busy, err_cnt);
    end
    wb_rst_i = 1'b0;
    sdr_init_done = 1'b1;
  endtask

  task automatic test_write();
    logic [AW-1:0] ea [4];
    logic [2:0]    ec [4];
    logic [DW-1:0] ed [4];
    int d0;
    ea = '{26'h100, 26'h104, 26'h108, 26'h10C};
    ec = '{3'b010, 3'b010, 3'b010, 3'b111};
    ed = '{32'h1, 32'h2, 32'h4, 32'h8};
    clear_log(); d0 = done_cnt;
    issue(1'b1, 26'h100, 5'd3, 32'h1);
    checks++;
    if (busy !== 1'b1 || wb_cyc_o !== 1'b1) begin
      failures++; $display("FAIL write_start: busy=%0b cyc=%0b required 1 1", busy, wb_cyc_o);
    end
    wait_done("write");
    @(negedge wb_clk_i);
    checks++;
    if (log_adr.size() != 4) begin
      failures++; $display("FAIL write_beats: got %0d required 4", log_adr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (log_adr[i] !== ea[i] || log_cti[i] !== ec[i] || log_dat[i] !== ed[i] ||
            log_sel[i] !== 4'hF || log_we[i] !== 1'b1) begin
          failures++;
          $display("FAIL write_beat%0d: adr=%0h cti=%0b dat=%0h sel=%0h we=%0b required adr=%0h cti=%0b dat=%0h sel=f we=1",
                   i, log_adr[i], log_cti[i], log_dat[i], log_sel[i], log_we[i], ea[i], ec[i], ed[i]);
        end
      end
    end
    checks++;
    if (done_cnt != d0 + 1 || wb_bte_o !== 2'b00) begin
      failures++; $display("FAIL write_done_once: pulses=%0d bte=%0b required 1 00", done_cnt - d0, wb_bte_o);
    end
  endtask

  task automatic test_readback();
    issue(1'b0, 26'h100, 5'd3, 32'h1);
    wait_done("readback");
    @(negedge wb_clk_i);
    checks++;
    if (err_cnt !== 16'h0 || err_vld !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL readback_clean: err_cnt=%0h err_vld=%0b busy=%0b required 0 0 0", err_cnt, err_vld, busy);
    end
  endtask

  task automatic test_corrupt();
    corrupt_en = 1'b1; corrupt_adr = 26'h108;
    issue(1'b0, 26'h100, 5'd3, 32'h1);
    wait_done("corrupt");
    corrupt_en = 1'b0;
    @(negedge wb_clk_i);
    checks++;
    if (err_cnt !== 16'h1 || err_addr !== 26'h108 || err_vld !== 1'b1) begin
      failures++;
      $display("FAIL corrupt_err: err_cnt=%0h err_addr=%0h err_vld=%0b required 1 108 1", err_cnt, err_addr, err_vld);
    end
    err_clr = 1'b1;
    @(posedge wb_clk_i); #1;
    err_clr = 1'b0;
    @(negedge wb_clk_i);
    checks++;
    if (err_cnt !== 16'h0 || err_addr !== '0 || err_vld !== 1'b0) begin
      failures++;
      $display("FAIL err_clr: err_cnt=%0h err_addr=%0h err_vld=%0b required 0 0 0", err_cnt, err_addr, err_vld);
    end
  endtask

  // Address wrap, a feedback-tap step, zero-seed substitution, low address bits ignored.
  task automatic test_wrap_tap();
    clear_log();
    issue(1'b1, 26'h3FF_FFFC, 5'd1, 32'h8000_0000);
    wait_done("wrap");
    issue(1'b1, 26'h203, 5'd0, 32'h0);
    wait_done("seed0");
    @(negedge wb_clk_i);
    checks++;
    if (log_adr.size() != 3) begin
      failures++; $display("FAIL wrap_beats: got %0d required 3", log_adr.size());
    end else begin
      checks++;
      if (log_adr[0] !== 26'h3FF_FFFC || log_dat[0] !== 32'h8000_0000 || log_cti[0] !== 3'b010) begin
        failures++; $display("FAIL wrap_beat0: adr=%0h dat=%0h cti=%0b required 3fffffc 80000000 010",
                             log_adr[0], log_dat[0], log_cti[0]);
      end
      checks++;
      if (log_adr[1] !== 26'h0 || log_dat[1] !== 32'h0040_0007 || log_cti[1] !== 3'b111) begin
        failures++; $display("FAIL wrap_beat1: adr=%0h dat=%0h cti=%0b required 0 400007 111",
                             log_adr[1], log_dat[1], log_cti[1]);
      end
      checks++;
      if (log_adr[2] !== 26'h200 || log_dat[2] !== 32'h1 || log_cti[2] !== 3'b111) begin
        failures++; $display("FAIL seed0_beat: adr=%0h dat=%0h cti=%0b required 200 1 111",
                             log_adr[2], log_dat[2], log_cti[2]);
      end
    end
  endtask

  task automatic test_init_gate();
    @(negedge wb_clk_i);
    sdr_init_done = 1'b0;
    cmd_we = 1'b1; cmd_addr = 26'h200; cmd_len = 5'd0; cmd_seed = 32'h5; cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge wb_clk_i);
      checks++;
      if (cmd_ready !== 1'b0 || wb_cyc_o !== 1'b0) begin
        failures++; $display("FAIL init_gate_hold%0d: cmd_ready=%0b cyc=%0b required 0 0", i, cmd_ready, wb_cyc_o);
      end
    end
    sdr_init_done = 1'b1;
    @(posedge wb_clk_i); #1;
    cmd_valid = 1'b0;
    @(negedge wb_clk_i);
    checks++;
    if (wb_cyc_o !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL init_gate_accept: cyc=%0b busy=%0b required 1 1", wb_cyc_o, busy);
    end
    wait_done("init_gate");
  endtask

  task automatic test_reset_mid();
    int d0, n = 0;
    issue(1'b1, 26'h400, 5'd7, 32'h9);
    while (!(wb_cyc_o === 1'b1 && wb_adr_o === 26'h404) && n < 20) begin @(negedge wb_clk_i); n++; end
    checks++;
    if (wb_adr_o !== 26'h404) begin
      failures++; $display("FAIL reset_mid_reach: adr=%0h required 404", wb_adr_o);
    end
    d0 = done_cnt;
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_mid_outputs: cyc=%0b stb=%0b busy=%0b done=%0b required 0 0 0 0",
                           wb_cyc_o, wb_stb_o, busy, done);
    end
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    checks++;
    if (done_cnt != d0 || wb_cyc_o !== 1'b0) begin
      failures++; $display("FAIL reset_mid_no_done: pulses=%0d cyc=%0b required 0 0", done_cnt - d0, wb_cyc_o);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    ack_en = 1'b0;
    issue(1'b1, 26'h300, 5'd3, 32'h3);
`ifdef WBM_TIMEOUT_EN
    @(negedge wb_clk_i);
    while (wb_cyc_o === 1'b1 && n < 50) begin n++; @(negedge wb_clk_i); end
    checks++;
    if (n != TO_CYC || done !== 1'b1 || timeout !== 1'b1) begin
      failures++; $display("FAIL timeout_abort: cyc_cycles=%0d done=%0b timeout=%0b required %0d 1 1",
                           n, done, timeout, TO_CYC);
    end
    ack_en = 1'b1;
    err_clr = 1'b1;
    @(posedge wb_clk_i); #1;
    err_clr = 1'b0;
    @(negedge wb_clk_i);
    checks++;
    if (timeout !== 1'b0) begin
      failures++; $display("FAIL timeout_clear: timeout=%0b required 0", timeout);
    end
`else
    repeat (20) begin @(negedge wb_clk_i); n++; end
    checks++;
    if (wb_cyc_o !== 1'b1 || timeout !== 1'b0 || wb_adr_o !== 26'h300) begin
      failures++; $display("FAIL no_timeout_wait: cyc=%0b timeout=%0b adr=%0h after %0d cycles required 1 0 300",
                           wb_cyc_o, timeout, wb_adr_o, n);
    end
    ack_en = 1'b1;
    wait_done("late_ack");
`endif
  endtask

  initial begin
    test_reset();
    test_write();
    test_readback();
    test_corrupt();
    test_wrap_tap();
    test_init_gate();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global time limit");
  end
endmodule
